// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed TX sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [1:0]  LINE_J      = 2'b10;
  localparam logic [1:0]  LINE_K      = 2'b01;
  localparam logic [1:0]  LINE_SE0    = 2'b00;
  localparam int unsigned STUFF_LIMIT = 6;

  // Swap J and K; used for NRZI transitions on a 0 bit.
  function automatic logic [1:0] line_toggle(input logic [1:0] line);
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/usb_tx_crc16.sv
// Serial CRC16 (poly 0x8005, init 0xFFFF), one data bit per enabled cycle.
module usb_tx_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ ((din ^ crc[15]) ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB full-speed packet transmitter: SYNC, PID, payload, optional CRC16, EOP with stuffing and NRZI.
// Define USB_TX_CRC16_EN to append a hardware CRC16 on data PIDs.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_LEN      = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_len,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       dplus_out,
  output logic       dminus_out
);

  localparam int unsigned      DIV_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [6:0]       LEN_MAX    = 7'(MAX_LEN);
  localparam logic [2:0]       STUFF_ONES = 3'(STUFF_LIMIT);

  tx_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [3:0]       bits_q, bits_d;
  logic [2:0]       ones_q, ones_d;
  logic [6:0]       bytes_q, bytes_d;
  logic [3:0]       pid_q, pid_d;
  logic [1:0]       eop_q, eop_d;
  logic             uflow_q, uflow_d;
  logic [1:0]       line_q, line_d;
  logic             busy_d, done_d, error_d, rd_d;
  logic             boundary, send, bit_v;
`ifdef USB_TX_CRC16_EN
  logic [15:0]      crc_val;
  logic             crc_on_q, crc_on_d;
`endif

  assign boundary   = (div_q == DIV_LAST);
  assign dplus_out  = line_q[1];
  assign dminus_out = line_q[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      shreg_q  <= '0;
      bits_q   <= '0;
      ones_q   <= '0;
      bytes_q  <= '0;
      pid_q    <= '0;
      eop_q    <= '0;
      uflow_q  <= 1'b0;
      line_q   <= LINE_J;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      fifo_rd  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      shreg_q  <= shreg_d;
      bits_q   <= bits_d;
      ones_q   <= ones_d;
      bytes_q  <= bytes_d;
      pid_q    <= pid_d;
      eop_q    <= eop_d;
      uflow_q  <= uflow_d;
      line_q   <= line_d;
      tx_busy  <= busy_d;
      tx_done  <= done_d;
      tx_error <= error_d;
      fifo_rd  <= rd_d;
    end
  end

  // Next-state: at each bit boundary either stuff a 0, shift the next raw bit, or load the next unit.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    shreg_d = shreg_q;
    bits_d  = bits_q;
    ones_d  = ones_q;
    bytes_d = bytes_q;
    pid_d   = pid_q;
    eop_d   = eop_q;
    uflow_d = uflow_q;
    line_d  = line_q;
    busy_d  = tx_busy;
    done_d  = 1'b0;
    error_d = 1'b0;
    rd_d    = 1'b0;
    send    = 1'b0;
    bit_v   = 1'b0;
`ifdef USB_TX_CRC16_EN
    crc_on_d = crc_on_q;
`endif

    if (state_q != ST_IDLE) div_d = boundary ? '0 : div_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: if (tx_start) begin
        state_d = ST_SYNC;
        div_d   = '0;
        busy_d  = 1'b1;
        pid_d   = tx_pid;
        bytes_d = (tx_len > LEN_MAX) ? LEN_MAX : tx_len;
        uflow_d = 1'b0;
        ones_d  = '0;
        send    = 1'b1;
        bit_v   = SYNC_BYTE[0];
        shreg_d = {8'h00, SYNC_BYTE} >> 1;
        bits_d  = 4'd7;
`ifdef USB_TX_CRC16_EN
        crc_on_d = (tx_pid[1:0] == 2'b11);
`endif
      end
      ST_EOP: if (boundary) begin
        if (eop_q == 2'd2) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = ~uflow_q;
          error_d = uflow_q;
          eop_d   = '0;
        end else begin
          eop_d = eop_q + 2'd1;
          if (eop_q == 2'd1) line_d = LINE_J;
        end
      end
      default: if (boundary) begin
        if (ones_q == STUFF_ONES) begin
          send = 1'b1;
        end else if (bits_q != '0) begin
          send    = 1'b1;
          bit_v   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bits_d  = bits_q - 4'd1;
        end else if (state_q == ST_SYNC) begin
          state_d = ST_PID;
          send    = 1'b1;
          bit_v   = pid_q[0];
          shreg_d = {8'h00, ~pid_q, pid_q} >> 1;
          bits_d  = 4'd7;
        end else if (state_q == ST_CRC) begin
          state_d = ST_EOP;
          line_d  = LINE_SE0;
          eop_d   = '0;
        end else if (bytes_q != '0) begin
          if (fifo_empty) begin
            state_d = ST_EOP;
            line_d  = LINE_SE0;
            eop_d   = '0;
            uflow_d = 1'b1;
          end else begin
            state_d = ST_DATA;
            rd_d    = 1'b1;
            bytes_d = bytes_q - 7'd1;
            send    = 1'b1;
            bit_v   = fifo_rdata[0];
            shreg_d = {8'h00, fifo_rdata} >> 1;
            bits_d  = 4'd7;
          end
        end else begin
`ifdef USB_TX_CRC16_EN
          if (crc_on_q) begin
            state_d = ST_CRC;
            send    = 1'b1;
            bit_v   = ~crc_val[15];
            shreg_d = bitrev16(~crc_val) >> 1;
            bits_d  = 4'd15;
          end else begin
            state_d = ST_EOP;
            line_d  = LINE_SE0;
            eop_d   = '0;
          end
`else
          state_d = ST_EOP;
          line_d  = LINE_SE0;
          eop_d   = '0;
`endif
        end
      end
    endcase

    // NRZI: a 0 (raw or stuffed) toggles the line, a 1 holds it
    if (send) begin
      line_d = bit_v ? line_q : line_toggle(line_q);
      ones_d = bit_v ? ones_q + 3'd1 : 3'd0;
    end
  end

`ifdef USB_TX_CRC16_EN
  // CRC covers only raw payload bits, never stuffed zeros
  usb_tx_crc16 u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (tx_start && (state_q == ST_IDLE)),
    .en    (send && (state_d == ST_DATA) && (ones_q != STUFF_ONES)),
    .din   (bit_v),
    .crc   (crc_val)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_on_q <= 1'b0;
    else        crc_on_q <= crc_on_d;
  end
`endif

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer: a list-based packet model feeds expected line symbols,
// and a negedge monitor compares mid-bit line samples and per-packet completion.
module tb_usb_tx_sequencer;
  import usb_tx_pkg::*;

  localparam int CPB  = 8;
  localparam int MAXL = 64;

  typedef struct {
    bit done;
    bit error;
    int rd;
    int cycles;
  } end_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] tx_len = 7'd0;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd, tx_busy, tx_done, tx_error, dplus_out, dminus_out;

  logic [1:0] exp_line[$];
  end_t       exp_end[$];
  logic [7:0] fifo_q[$];

  int checks = 0;
  int errors = 0;
  int pkts_sent = 0;
  int pkts_done = 0;
  bit mon_en = 1'b1;

  usb_tx_sequencer #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAXL)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .tx_pid     (tx_pid),
    .tx_len     (tx_len),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .dplus_out  (dplus_out),
    .dminus_out (dminus_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // Show-ahead FIFO: the head is consumed during the fifo_rd cycle.
  always @(negedge clk) begin
    if (fifo_rd && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  // Reference model: raw bit list -> stuffing pass -> NRZI pass -> EOP symbols.
  task automatic build_expect(input logic [3:0] pid, input int len);
    bit         raw[$];
    bit         stf[$];
    int         n, nsend, ones;
    bit         under, use_crc;
    logic [7:0] b;
    logic [15:0] r;
    logic [1:0] lvl;
    end_t       ee;
    n     = (len > MAXL) ? MAXL : len;
    nsend = (fifo_q.size() < n) ? fifo_q.size() : n;
    under = (nsend < n);
    b = SYNC_BYTE;
    for (int i = 0; i < 8; i++) raw.push_back(b[i]);
    b = {~pid, pid};
    for (int i = 0; i < 8; i++) raw.push_back(b[i]);
    for (int j = 0; j < nsend; j++) begin
      b = fifo_q[j];
      for (int i = 0; i < 8; i++) raw.push_back(b[i]);
    end
`ifdef USB_TX_CRC16_EN
    use_crc = !under && (pid[1:0] == 2'b11);
`else
    use_crc = 1'b0;
`endif
    if (use_crc) begin
      // reflected CRC-16/USB, result sent LSB first
      r = 16'hFFFF;
      for (int j = 0; j < nsend; j++) begin
        b = fifo_q[j];
        for (int i = 0; i < 8; i++) r = (b[i] ^ r[0]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      r = ~r;
      for (int i = 0; i < 16; i++) raw.push_back(r[i]);
    end
    ones = 0;
    foreach (raw[i]) begin
      stf.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        stf.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = LINE_J;
    foreach (stf[i]) begin
      if (!stf[i]) lvl = (lvl == LINE_J) ? LINE_K : LINE_J;
      exp_line.push_back(lvl);
    end
    exp_line.push_back(LINE_SE0);
    exp_line.push_back(LINE_SE0);
    exp_line.push_back(LINE_J);
    ee.done   = !under;
    ee.error  = under;
    ee.rd     = nsend;
    ee.cycles = (stf.size() + 3) * CPB;
    exp_end.push_back(ee);
  endtask

  // Monitor: samples the lines mid-bit while busy, checks completion when busy falls.
  int         mon_cyc = 0;
  int         mon_rd = 0;
  bit         in_pkt = 1'b0;
  logic [1:0] mon_sym;
  end_t       mon_end;

  always @(negedge clk) begin
    if (!mon_en || !n_rst) begin
      in_pkt = 1'b0;
    end else if (tx_busy) begin
      if (!in_pkt) begin
        in_pkt  = 1'b1;
        mon_cyc = 0;
        mon_rd  = 0;
      end
      if (mon_cyc % CPB == CPB / 2) begin
        if (exp_line.size() == 0) chk("extra_bit", 1, 0);
        else begin
          mon_sym = exp_line.pop_front();
          chk($sformatf("line_bit%0d", mon_cyc / CPB), {dplus_out, dminus_out}, mon_sym);
        end
      end
      if (fifo_rd) mon_rd++;
      if (tx_done || tx_error) chk("pulse_while_busy", {tx_done, tx_error}, 0);
      mon_cyc++;
    end else if (in_pkt) begin
      in_pkt = 1'b0;
      if (exp_end.size() == 0) chk("unexpected_end", 1, 0);
      else begin
        mon_end = exp_end.pop_front();
        chk("tx_done", tx_done, mon_end.done);
        chk("tx_error", tx_error, mon_end.error);
        chk("fifo_rd_count", mon_rd, mon_end.rd);
        chk("busy_cycles", mon_cyc, mon_end.cycles);
        chk("bits_unsent", exp_line.size(), 0);
      end
      exp_line.delete();
      pkts_done++;
    end else begin
      chk("idle_line", {dplus_out, dminus_out}, LINE_J);
      chk("idle_pulses", {tx_done, tx_error, fifo_rd}, 0);
    end
  end

  task automatic wait_end();
    int n;
    n = 0;
    while (pkts_done != pkts_sent && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (pkts_done != pkts_sent) begin
      chk("packet_timeout", pkts_done, pkts_sent);
      finish_run();
    end
  endtask

  task automatic send_pkt(input logic [3:0] pid, input int len, input bit poke);
    build_expect(pid, len);
    pkts_sent++;
    @(negedge clk);
    tx_start = 1'b1;
    tx_pid   = pid;
    tx_len   = 7'(len);
    @(negedge clk);
    tx_start = 1'b0;
    tx_pid   = 4'($urandom);
    tx_len   = 7'($urandom);
    if (poke) begin
      repeat (150) @(negedge clk);
      tx_start = 1'b1;
      tx_pid   = 4'h2;
      tx_len   = 7'd0;
      @(negedge clk);
      tx_start = 1'b0;
    end
    wait_end();
  endtask

  task automatic load_fifo(input int n, input logic [7:0] first, input bit ramp);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(ramp ? 8'(first + 8'(i)) : first);
    fifo_refresh();
  endtask

  initial begin
    bit saw;
    int len, avail;
    logic [3:0] pid;
    fifo_refresh();
    repeat (3) @(negedge clk);
    chk("reset_line", {dplus_out, dminus_out}, LINE_J);
    chk("reset_busy", tx_busy, 0);
    chk("reset_pulses", {tx_done, tx_error, fifo_rd}, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    load_fifo(0, 8'h00, 1'b0);
    send_pkt(4'h2, 0, 1'b0);                 // ACK
    load_fifo(4, 8'h00, 1'b1);
    send_pkt(4'h3, 4, 1'b0);                 // DATA0 00 01 02 03
    load_fifo(2, 8'hFF, 1'b0);
    send_pkt(4'h3, 2, 1'b0);                 // long run of ones
    load_fifo(1, 8'h5A, 1'b0);
    send_pkt(4'h3, 3, 1'b0);                 // underrun after one pop
    load_fifo(0, 8'h00, 1'b0);
    send_pkt(4'hB, 0, 1'b0);                 // DATA1 zero length
    load_fifo(3, 8'hAA, 1'b1);
    send_pkt(4'h3, 3, 1'b1);                 // tx_start mid-DATA ignored
    load_fifo(70, 8'h10, 1'b1);
    send_pkt(4'hB, 100, 1'b0);               // length clamped to MAX_LEN
    fifo_q.delete();
    fifo_refresh();

    // Reset in the middle of a payload byte
    mon_en = 1'b0;
    load_fifo(5, 8'hF0, 1'b1);
    @(negedge clk);
    tx_start = 1'b1;
    tx_pid   = 4'h3;
    tx_len   = 7'd5;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (200) @(negedge clk);
    chk("busy_before_abort", tx_busy, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_line", {dplus_out, dminus_out}, LINE_J);
    chk("abort_busy", tx_busy, 0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw |= tx_done | tx_error;
    end
    n_rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      saw |= tx_done | tx_error | tx_busy;
    end
    chk("abort_no_pulse", saw, 0);
    fifo_q.delete();
    fifo_refresh();
    mon_en = 1'b1;
    load_fifo(2, 8'h7E, 1'b1);
    send_pkt(4'h3, 2, 1'b0);

    for (int k = 0; k < 14; k++) begin
      len   = $urandom_range(0, 9);
      avail = len;
      pid   = 4'($urandom);
      if (len > 0 && $urandom_range(0, 4) == 0) avail = $urandom_range(0, len - 1);
      fifo_q.delete();
      for (int i = 0; i < avail; i++)
        fifo_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      fifo_refresh();
      send_pkt(pid, len, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    finish_run();
  end

endmodule
